sar_step_controller: RTL

//   Successive-approximation control for the 8-bit SAR ADC. Runs the binary search against the

---
 rtl/sar_pkg.sv | 18 +
 rtl/sar_step_controller_if.sv | 31 +++
 rtl/sar_settle_cnt.sv | 26 ++
 rtl/sar_step_controller.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared phase encodings, default sizes and code limits for the SAR step controller
package sar_pkg;

  typedef enum logic [1:0] {
    SAR_IDLE  = 2'b00,
    SAR_CONV  = 2'b01,
    SAR_TRACK = 2'b10,
    SAR_HOLD  = 2'b11
  } sar_state_e;

  localparam int SAR_WIDTH = 8;
  localparam int SAR_TMR_W = 6;

  // Tracking saturates at these codes instead of wrapping.
  localparam logic [SAR_WIDTH-1:0] SAR_CODE_MAX = '1;
  localparam logic [SAR_WIDTH-1:0] SAR_CODE_MIN = '0;

endpackage

// File: rtl/sar_step_controller_if.sv
// rtl/sar_step_controller_if.sv - control, comparator, timer and result signals of the SAR step controller
interface sar_step_controller_if
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH,
  parameter int TMR_W = SAR_TMR_W
);
  logic             start;
  logic             stop;
  logic             track_req;
  logic             comp_in;
  logic [TMR_W-1:0] settle_cyc;
  logic             ready;
  logic [WIDTH-1:0] sar_out;
  logic [1:0]       state_p;
  logic             inc;
  logic             dcr;
  logic             done;
  logic             busy;

  modport master (
    output start, stop, track_req, comp_in, settle_cyc, ready,
    input  sar_out, state_p, inc, dcr, done, busy
  );

  modport slave (
    input  start, stop, track_req, comp_in, settle_cyc, ready,
    output sar_out, state_p, inc, dcr, done, busy
  );

endinterface

// File: rtl/sar_settle_cnt.sv
// rtl/sar_settle_cnt.sv - per-trial settle down-counter; a trial decides when the count reaches zero
module sar_settle_cnt #(
  parameter int TMR_W = 6
) (
  input  logic             clockt,
  input  logic             resetn,
  input  logic             load,
  input  logic [TMR_W-1:0] value,
  output logic             zero
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clockt or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sar_step_controller.sv
// rtl/sar_step_controller.sv - SAR binary search and optional +/-1 tracking (tracking built when SAR_TRACK_EN is defined)
module sar_step_controller
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH,
  parameter int TMR_W = SAR_TMR_W
) (
  input  logic            clockt,
  input  logic            resetn,
  sar_step_controller_if.slave bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);

  sar_state_e       state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] code;
  logic             done_r;
  logic             cnt_zero;
  logic             cnt_load;
  logic [TMR_W-1:0] cnt_value;
  logic             last_bit;
  logic             track_go;

  assign last_bit = (idx == '0);

`ifdef SAR_TRACK_EN
  logic inc_r;
  logic dcr_r;
  assign track_go = bus.track_req;
  assign bus.inc  = inc_r;
  assign bus.dcr  = dcr_r;
`else
  logic unused_track_req;
  assign unused_track_req = bus.track_req;
  assign track_go = 1'b0;
  assign bus.inc  = 1'b0;
  assign bus.dcr  = 1'b0;
`endif

  // Stop reloads with zero so an aborted trial never leaves a stale count behind.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = bus.settle_cyc;
    if (bus.stop) begin
      cnt_load  = 1'b1;
      cnt_value = '0;
    end else begin
      case (state)
        SAR_IDLE:  cnt_load = bus.start;
        SAR_CONV:  cnt_load = cnt_zero && !last_bit;
        SAR_HOLD:  cnt_load = bus.ready && track_go;
        SAR_TRACK: cnt_load = bus.start || cnt_zero;
        default:   cnt_load = 1'b0;
      endcase
    end
  end

  sar_settle_cnt #(.TMR_W(TMR_W)) u_settle (
    .clockt (clockt),
    .resetn (resetn),
    .load   (cnt_load),
    .value  (cnt_value),
    .zero   (cnt_zero)
  );

  always_ff @(posedge clockt or negedge resetn) begin
    if (!resetn) begin
      state  <= SAR_IDLE;
      idx    <= TOP_IDX;
      code   <= '0;
      done_r <= 1'b0;
`ifdef SAR_TRACK_EN
      inc_r  <= 1'b0;
      dcr_r  <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
`ifdef SAR_TRACK_EN
      inc_r  <= 1'b0;
      dcr_r  <= 1'b0;
`endif
      if (bus.stop) begin
        state <= SAR_IDLE;
        if (state == SAR_CONV) code <= '0;
      end else begin
        case (state)
          SAR_IDLE: begin
            if (bus.start) begin
              state <= SAR_CONV;
              code  <= MSB_ONE;
              idx   <= TOP_IDX;
            end
          end
          SAR_CONV: begin
            if (cnt_zero) begin
              code[idx] <= bus.comp_in;
              if (last_bit) begin
                state  <= SAR_HOLD;
                done_r <= 1'b1;
              end else begin
                code[idx - 1'b1] <= 1'b1;
                idx              <= idx - 1'b1;
              end
            end
          end
          SAR_HOLD: begin
            if (bus.ready) state <= track_go ? SAR_TRACK : SAR_IDLE;
          end
`ifdef SAR_TRACK_EN
          SAR_TRACK: begin
            if (bus.start) begin
              state <= SAR_CONV;
              code  <= MSB_ONE;
              idx   <= TOP_IDX;
            end else if (cnt_zero) begin
              if (bus.comp_in && !(&code)) begin
                code  <= code + 1'b1;
                inc_r <= 1'b1;
              end else if (!bus.comp_in && (|code)) begin
                code  <= code - 1'b1;
                dcr_r <= 1'b1;
              end
            end
          end
`endif
          default: state <= SAR_IDLE;
        endcase
      end
    end
  end

  assign bus.sar_out = code;
  assign bus.state_p = state;
  assign bus.done    = done_r;
  assign bus.busy    = (state == SAR_CONV);

endmodule
